// File: rtl/mem_port_arbiter_if.sv
// Request/response bus between the fetch/LSU requesters, the arbiter and main_memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              f_req_valid;
  logic              f_req_ready;
  logic [ADDR_W-1:0] f_req_addr;
  logic              f_resp_valid;
  logic [DATA_W-1:0] f_resp_data;

  logic              d_req_valid;
  logic              d_req_ready;
  logic              d_req_we;
  logic [ADDR_W-1:0] d_req_addr;
  logic [DATA_W-1:0] d_req_wdata;
  logic              d_resp_valid;
  logic [DATA_W-1:0] d_resp_data;

  logic [ADDR_W-1:0] mem_raddr;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  f_req_valid, f_req_addr,
    input  d_req_valid, d_req_we, d_req_addr, d_req_wdata,
    input  mem_rdata,
    output f_req_ready, f_resp_valid, f_resp_data,
    output d_req_ready, d_resp_valid, d_resp_data,
    output mem_raddr, mem_waddr, mem_wdata, mem_wen, busy
  );

  modport master (
    output f_req_valid, f_req_addr,
    output d_req_valid, d_req_we, d_req_addr, d_req_wdata,
    output mem_rdata,
    input  f_req_ready, f_resp_valid, f_resp_data,
    input  d_req_ready, d_resp_valid, d_resp_data,
    input  mem_raddr, mem_waddr, mem_wdata, mem_wen, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch F, load/store D) arbiter in front of a single main_memory port,
// with valid/ready requests, a bounded read-latency tracker and registered responses.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int FIXED_PRIO   = 0
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = 3;

  typedef enum logic { ST_IDLE, ST_RD_WAIT } state_e;
  typedef enum logic { PORT_F, PORT_D }      port_e;

  state_e            state_q, state_d;
  port_e             last_grant_q, last_grant_d;
  port_e             rd_id_q, rd_id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              f_resp_valid_q, f_resp_valid_d;
  logic              d_resp_valid_q, d_resp_valid_d;
  logic [DATA_W-1:0] f_resp_data_q, f_resp_data_d;
  logic [DATA_W-1:0] d_resp_data_q, d_resp_data_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              grant_f, grant_d, wen;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    rd_id_d        = rd_id_q;
    cnt_d          = cnt_q;
    f_resp_valid_d = 1'b0;
    d_resp_valid_d = 1'b0;
    f_resp_data_d  = f_resp_data_q;
    d_resp_data_d  = d_resp_data_q;
    raddr_d        = raddr_q;
    waddr_d        = waddr_q;
    wdata_d        = wdata_q;
    wen            = 1'b0;
    grant_f        = 1'b0;
    grant_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Grants are suppressed while reset is held so mem_wen cannot assert.
        if (rst) begin
          if (bus.f_req_valid && bus.d_req_valid) begin
            if (FIXED_PRIO != 0 || last_grant_q == PORT_F) grant_d = 1'b1;
            else                                           grant_f = 1'b1;
          end else if (bus.f_req_valid) begin
            grant_f = 1'b1;
          end else if (bus.d_req_valid) begin
            grant_d = 1'b1;
          end
        end

        if (grant_f) begin
          raddr_d      = bus.f_req_addr;
          last_grant_d = PORT_F;
          rd_id_d      = PORT_F;
          cnt_d        = '0;
          state_d      = ST_RD_WAIT;
        end

        if (grant_d) begin
          raddr_d      = bus.d_req_addr;
          last_grant_d = PORT_D;
          if (bus.d_req_we) begin
            waddr_d        = bus.d_req_addr;
            wdata_d        = bus.d_req_wdata;
            wen            = 1'b1;
            d_resp_valid_d = 1'b1;
            d_resp_data_d  = '0;
          end else begin
            rd_id_d = PORT_D;
            cnt_d   = '0;
            state_d = ST_RD_WAIT;
          end
        end
      end

      ST_RD_WAIT: begin
        // Last wait cycle: mem_rdata is valid now and is registered into the response.
        if (cnt_q == CNT_W'(READ_LATENCY - 1)) begin
          state_d = ST_IDLE;
          if (rd_id_q == PORT_F) begin
            f_resp_valid_d = 1'b1;
            f_resp_data_d  = bus.mem_rdata;
          end else begin
            d_resp_valid_d = 1'b1;
            d_resp_data_d  = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      last_grant_q   <= PORT_D;
      rd_id_q        <= PORT_F;
      cnt_q          <= '0;
      f_resp_valid_q <= 1'b0;
      d_resp_valid_q <= 1'b0;
      f_resp_data_q  <= '0;
      d_resp_data_q  <= '0;
      raddr_q        <= '0;
      waddr_q        <= '0;
      wdata_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update on the same edge.
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      rd_id_q        <= rd_id_d;
      cnt_q          <= cnt_d;
      f_resp_valid_q <= f_resp_valid_d;
      d_resp_valid_q <= d_resp_valid_d;
      f_resp_data_q  <= f_resp_data_d;
      d_resp_data_q  <= d_resp_data_d;
      raddr_q        <= raddr_d;
      waddr_q        <= waddr_d;
      wdata_q        <= wdata_d;
    end
  end

  // Memory address/data follow the grant combinationally and otherwise hold the last value.
  assign bus.mem_raddr    = raddr_d;
  assign bus.mem_waddr    = waddr_d;
  assign bus.mem_wdata    = wdata_d;
  assign bus.mem_wen      = wen;
  assign bus.f_req_ready  = grant_f;
  assign bus.d_req_ready  = grant_d;
  assign bus.f_resp_valid = f_resp_valid_q;
  assign bus.f_resp_data  = f_resp_data_q;
  assign bus.d_resp_valid = d_resp_valid_q;
  assign bus.d_resp_data  = d_resp_data_q;
  assign bus.busy         = (state_q == ST_RD_WAIT);

endmodule
